// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce path: FSM state encoding
// and the default debounce window.
package key_pkg;

   localparam int DEBOUNCE_CYC_DEFAULT = 500000;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input; the reset
// value lets each input start at its own inactive level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous input into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RST_VAL;
         sync_r <= RST_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: polarity normalisation, synchronizer, four-state
// accept/bounce FSM and registered level plus press/release strobes.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEFAULT,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             act_s;
   logic             smp_s;
   key_state_e       state_r;
   key_state_e       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             level_s;
   logic             press_s;
   logic             release_s;
   logic             level_r;
   logic             press_r;
   logic             release_r;

   assign act_s = key_in ^ KEY_ACTIVE_LOW;

   sync_2ff #(
      .RST_VAL (1'b0)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (act_s),
      .q     (smp_s)
   );

   // Next-state, counter and output decode; a disagreeing sample in a wait
   // state falls back to the stable state so the window restarts from zero.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (smp_s) begin
               state_s = ST_PRESS_WAIT;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_IDLE;
               cnt_s   = cnt_r;
            end
         end
         ST_PRESS_WAIT: begin
            if (!smp_s) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_PRESSED;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_PRESS_WAIT;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_PRESSED: begin
            if (!smp_s) begin
               state_s = ST_RELEASE_WAIT;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_PRESSED;
               cnt_s   = cnt_r;
            end
         end
         ST_RELEASE_WAIT: begin
            if (smp_s) begin
               state_s = ST_PRESSED;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_RELEASE_WAIT;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase

      level_s   = (state_s == ST_PRESSED) || (state_s == ST_RELEASE_WAIT);
      press_s   = (state_r == ST_PRESS_WAIT) && (state_s == ST_PRESSED);
      release_s = (state_r == ST_RELEASE_WAIT) && (state_s == ST_IDLE);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         level_r   <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         level_r   <= level_s;
         press_r   <= press_s;
         release_r <= release_s;
      end
   end

   assign key_level   = level_r;
   assign key_press   = press_r;
   assign key_release = release_r;

endmodule
